// File: rtl/gb_fb_pkg.sv
// Shared constants and types for the GameBoy LCD framebuffer write path.
package gb_fb_pkg;

  localparam int GB_H           = 160;
  localparam int GB_V           = 144;
  localparam int GB_FRAME_WORDS = GB_H * GB_V;

  // IDLE: waiting for frame_start, FILL: accepting pixels,
  // DONE: frame complete and waiting for vblank, OFF: LCD disabled.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2,
    OFF  = 2'd3
  } fb_state_t;

  typedef logic [1:0] shade_t;

endpackage

// File: rtl/gb_fb_addr_gen.sv
// Pixel position tracker for the framebuffer writer.
// Keeps x/y and a running linear address (bank base + y*H + x) that only
// ever increments, so no multiplier is needed. i_clear restarts at (0,0) of
// bank i_bank; when i_clear and i_inc are both high the pixel consumed this
// cycle is (0,0) of the new frame. o_addr / o_last describe the pixel that
// would be consumed this cycle.
import gb_fb_pkg::*;

module gb_fb_addr_gen #(
  parameter int H_PIXELS = GB_H,
  parameter int V_LINES  = GB_V,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_bank,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam int X_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int Y_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [X_W-1:0]    X_MAX      = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0]    Y_MAX      = Y_W'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(H_PIXELS * V_LINES);

  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;

  logic [X_W-1:0]    w_cur_x;
  logic [Y_W-1:0]    w_cur_y;
  logic [ADDR_W-1:0] w_cur_addr;

  // Position of the pixel that would be written this cycle.
  always_comb begin
    w_cur_x    = r_x;
    w_cur_y    = r_y;
    w_cur_addr = r_addr;
    if (i_clear) begin
      w_cur_x    = '0;
      w_cur_y    = '0;
      w_cur_addr = i_bank ? BANK1_BASE : '0;
    end
  end

  assign o_addr = w_cur_addr;
  assign o_last = (w_cur_x == X_MAX) && (w_cur_y == Y_MAX);

  // Advance past the consumed pixel, or just latch the restart position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_inc) begin
      if (w_cur_x == X_MAX) begin
        r_x <= '0;
        r_y <= (w_cur_y == Y_MAX) ? '0 : w_cur_y + Y_W'(1);
      end else begin
        r_x <= w_cur_x + X_W'(1);
        r_y <= w_cur_y;
      end
      r_addr <= w_cur_addr + ADDR_W'(1);
    end else if (i_clear) begin
      r_x    <= w_cur_x;
      r_y    <= w_cur_y;
      r_addr <= w_cur_addr;
    end
  end

endmodule

// File: rtl/gb_fb_write_ctrl.sv
// GameBoy LCD framebuffer write controller.
// Pixels from the PPU are written into the back bank of a two-bank RAM; the
// display bank flips to a completed frame only while the VGA reader is in
// vblank, so the reader never sees a half-written frame.
// Handshake: PX_VALID has no back-pressure. Every cycle PX_VALID is high the
// pixel on LD is consumed, and the matching write appears on wr_en/wr_addr/
// wr_data exactly one cycle later; wr_en is high for one cycle per pixel.
import gb_fb_pkg::*;

module gb_fb_write_ctrl #(
  parameter int H_PIXELS = GB_H,
  parameter int V_LINES  = GB_V,
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PX_VALID,
  input  logic [1:0]        LD,
  input  logic              frame_start,
  input  logic              lcd_on,
  input  logic              rd_vblank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              disp_bank,
  output logic              blank_out,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              resync_err,
  output logic              ovf_err,
  output fb_state_t         dbg_state
);

  fb_state_t r_state;
  fb_state_t w_next_state;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  shade_t            r_wr_data;
  logic              r_disp_bank;
  logic              r_blank;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_resync_err;
  logic              r_ovf_err;
  logic              r_done_seen;

  logic              w_write;
  logic              w_clear;
  logic              w_bank;
  logic              w_swap;
  logic              w_drop;
  logic              w_resync;
  logic              w_ovf;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;

  gb_fb_addr_gen #(
    .H_PIXELS (H_PIXELS),
    .V_LINES  (V_LINES),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_bank  (w_bank),
    .i_inc   (w_write),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and per-cycle actions; LCD-off overrides everything.
  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    w_clear      = 1'b0;
    w_bank       = ~r_disp_bank;
    w_swap       = 1'b0;
    w_drop       = 1'b0;
    w_resync     = 1'b0;
    w_ovf        = 1'b0;
    if (!lcd_on) begin
      w_next_state = OFF;
    end else begin
      case (r_state)
        OFF: w_next_state = IDLE;
        IDLE: begin
          if (frame_start) begin
            w_clear      = 1'b1;
            w_write      = PX_VALID;
            w_next_state = FILL;
          end else if (PX_VALID && r_done_seen) begin
            w_ovf = 1'b1;
          end
        end
        FILL: begin
          if (frame_start) begin
            // Restart the same back bank; the partial frame is abandoned.
            w_resync = 1'b1;
            w_clear  = 1'b1;
            w_write  = PX_VALID;
          end else if (PX_VALID) begin
            w_write = 1'b1;
            if (w_last) w_next_state = DONE;
          end
        end
        DONE: begin
          w_swap = rd_vblank;
          // After a swap the new back bank is the old display bank.
          if (rd_vblank) w_bank = r_disp_bank;
          if (frame_start) begin
            w_drop       = ~rd_vblank;
            w_clear      = 1'b1;
            w_write      = PX_VALID;
            w_next_state = FILL;
          end else begin
            w_ovf = PX_VALID;
            if (rd_vblank) w_next_state = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Write port, bank swap, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_disp_bank  <= 1'b0;
      r_blank      <= 1'b1;
      r_frame_cnt  <= '0;
      r_drop_cnt   <= '0;
      r_resync_err <= 1'b0;
      r_ovf_err    <= 1'b0;
      r_done_seen  <= 1'b0;
    end else begin
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr <= w_addr;
        r_wr_data <= LD;
      end
      if (w_swap) begin
        r_disp_bank <= ~r_disp_bank;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      if (!lcd_on)     r_blank <= 1'b1;
      else if (w_swap) r_blank <= 1'b0;
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      if (w_resync) r_resync_err <= 1'b1;
      if (w_ovf)    r_ovf_err    <= 1'b1;
      if ((r_state == FILL) && (w_next_state == DONE)) r_done_seen <= 1'b1;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign disp_bank  = r_disp_bank;
  assign blank_out  = r_blank;
  assign frame_cnt  = r_frame_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign resync_err = r_resync_err;
  assign ovf_err    = r_ovf_err;
  assign dbg_state  = r_state;

endmodule
